// File: rtl/cmp_multi_if.sv
// Bus bundle for cmp_multi: reference-word write port, scan control and
// the match_valid/match_ready reporting handshake.
interface cmp_multi_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    parameter int DEPTH    = 512
);
    localparam int AW        = $clog2(DEPTH);
    localparam int LW        = $clog2(RATIO);
    localparam int CMP_WIDTH = IN_WIDTH * RATIO;

    logic [IN_WIDTH-1:0]  din;
    logic                 wr_en;
    logic [AW+LW-1:0]     wr_addr;
    logic [AW:0]          hash_count;
    logic                 multi;
    logic [CMP_WIDTH-1:0] cmp_data;
    logic                 start;
    logic                 busy;
    logic                 match_valid;
    logic                 match_ready;
    logic [AW-1:0]        match_num;
    logic                 done;
    logic                 found;

    modport master (
        output din, wr_en, wr_addr, hash_count, multi, cmp_data, start, match_ready,
        input  busy, match_valid, match_num, done, found
    );

    modport slave (
        input  din, wr_en, wr_addr, hash_count, multi, cmp_data, start, match_ready,
        output busy, match_valid, match_num, done, found
    );
endinterface

// File: rtl/cmp_multi.sv
// Multi-entry comparator: holds DEPTH reference words written lane by lane
// and scans the first min(hash_count, DEPTH) of them against cmp_data,
// reporting matches one at a time over a valid/ready handshake.
module cmp_multi #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    parameter int DEPTH    = 512
) (
    input logic         CLK,
    input logic         rst_n,
    cmp_multi_if.slave  bus
);
    localparam int CMP_WIDTH = IN_WIDTH * RATIO;
    localparam int AW        = $clog2(DEPTH);
    localparam int LW        = $clog2(RATIO);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_SCAN,
        S_HOLD,
        S_END
    } state_t;

    state_t state_q, state_d;

    logic [AW:0]    neff_q, neff_d;
    logic           multi_q, multi_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [AW-1:0]  match_num_q, match_num_d;
    logic           found_q, found_d;
    logic           prime_q, prime_d;

    logic [CMP_WIDTH-1:0] mem [DEPTH];
    logic [CMP_WIDTH-1:0] mem_rd_q;
    logic [CMP_WIDTH-1:0] data_q;

    logic hit;
    logic last;
    logic rd_more;

    assign hit     = (data_q == bus.cmp_data);
    assign last    = ({1'b0, idx_q} == neff_q - 1'b1);
    // Address stops at the last effective entry so it never runs past Neff.
    assign rd_more = (({1'b0, rd_addr_q} + 1'b1) < neff_q);

    // Reference memory write port, locked out while a scan is in progress.
    always_ff @(posedge CLK) begin
        if (bus.wr_en && state_q == S_IDLE)
            mem[bus.wr_addr[AW+LW-1:LW]][bus.wr_addr[LW-1:0]*IN_WIDTH +: IN_WIDTH] <= bus.din;
    end

    // Two-stage read: BRAM read register, then a separate fabric register.
    always_ff @(posedge CLK) begin
        mem_rd_q <= mem[rd_addr_q];
        data_q   <= mem_rd_q;
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_PRIME;
            S_PRIME: begin
                if (neff_q == '0)  state_d = S_END;
                else if (prime_q)  state_d = S_SCAN;
            end
            S_SCAN: begin
                if (hit)       state_d = S_HOLD;
                else if (last) state_d = S_END;
            end
            S_HOLD: begin
                if (bus.match_ready) state_d = (multi_q && !last) ? S_PRIME : S_END;
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from state plus registered match data.
    always_comb begin
        bus.busy        = (state_q != S_IDLE);
        bus.match_valid = (state_q == S_HOLD);
        bus.done        = (state_q == S_END);
        bus.match_num   = match_num_q;
        bus.found       = found_q;
    end

    // Scan datapath: latched parameters, read address, index and match capture.
    always_comb begin
        neff_d      = neff_q;
        multi_d     = multi_q;
        rd_addr_d   = rd_addr_q;
        idx_d       = idx_q;
        match_num_d = match_num_q;
        found_d     = found_q;
        prime_d     = prime_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    neff_d    = (bus.hash_count > DEPTH_C) ? DEPTH_C : bus.hash_count;
                    multi_d   = bus.multi;
                    rd_addr_d = '0;
                    idx_d     = '0;
                    found_d   = 1'b0;
                    prime_d   = 1'b0;
                end
            end
            S_PRIME: begin
                // prime_q toggles, so it is back at 0 whenever PRIME is re-entered.
                prime_d = !prime_q;
                if (rd_more) rd_addr_d = rd_addr_q + 1'b1;
            end
            S_SCAN: begin
                if (rd_more) rd_addr_d = rd_addr_q + 1'b1;
                if (hit)        match_num_d = idx_q;
                else if (!last) idx_d = idx_q + 1'b1;
            end
            S_HOLD: begin
                if (bus.match_ready) begin
                    found_d = 1'b1;
                    if (multi_q && !last) begin
                        idx_d     = idx_q + 1'b1;
                        rd_addr_d = idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            neff_q      <= '0;
            multi_q     <= 1'b0;
            rd_addr_q   <= '0;
            idx_q       <= '0;
            match_num_q <= '0;
            found_q     <= 1'b0;
            prime_q     <= 1'b0;
        end else begin
            neff_q      <= neff_d;
            multi_q     <= multi_d;
            rd_addr_q   <= rd_addr_d;
            idx_q       <= idx_d;
            match_num_q <= match_num_d;
            found_q     <= found_d;
            prime_q     <= prime_d;
        end
    end
endmodule

// File: tb/tb_cmp_multi.sv
// Self-checking bench for cmp_multi: directed scenarios plus randomized scans,
// each checked cycle by cycle against an event schedule derived from the
// reference memory contents.
module tb_cmp_multi;
    localparam int IW = 8;
    localparam int R  = 4;
    localparam int D  = 64;
    localparam int AW = $clog2(D);
    localparam int LW = $clog2(R);
    localparam int CW = IW * R;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    cmp_multi_if #(.IN_WIDTH(IW), .RATIO(R), .DEPTH(D)) bus ();

    cmp_multi #(.IN_WIDTH(IW), .RATIO(R), .DEPTH(D)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [CW-1:0] ref_mem [D];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input int w, input logic [CW-1:0] val);
        for (int l = 0; l < R; l++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = (AW+LW)'(w * R + (R - 1 - l));
            bus.din     = val[(R - 1 - l) * IW +: IW];
            step();
        end
        bus.wr_en = 1'b0;
        ref_mem[w] = val;
    endtask

    // Runs one scan starting at cycle T; observation n reflects cycle T+n.
    // wr_at / start_at inject a stray write of cand's low lane into word 6
    // or a stray start pulse at that cycle (0 = none).
    task automatic run_scan(input string name, input int hc, input bit mlt,
                            input logic [CW-1:0] cand, input int stall,
                            input int wr_at, input int start_at);
        int neff, t, done_c, hold_cnt;
        bit exp_v;
        int exp_num;
        int vc[$];
        int hs[$];
        int ix[$];
        neff   = (hc > D) ? D : hc;
        done_c = 2;
        t      = 3;
        for (int k = 0; k < neff; k++) begin
            if (ref_mem[k] == cand) begin
                vc.push_back(t + 1);
                hs.push_back(t + 1 + stall);
                ix.push_back(k);
                if (mlt && k < neff - 1) begin
                    t = t + 1 + stall + 3;
                end else begin
                    done_c = t + 1 + stall + 1;
                    break;
                end
            end else begin
                if (k == neff - 1) done_c = t + 1;
                t++;
            end
        end

        bus.hash_count  = (AW+1)'(hc);
        bus.multi       = mlt;
        bus.cmp_data    = cand;
        bus.start       = 1'b1;
        bus.match_ready = 1'b0;
        step();
        bus.start = 1'b0;
        hold_cnt  = 0;
        for (int n = 1; n <= done_c + 2; n++) begin
            exp_v   = 1'b0;
            exp_num = 0;
            foreach (vc[i]) begin
                if (n >= vc[i] && n <= hs[i]) begin
                    exp_v   = 1'b1;
                    exp_num = ix[i];
                end
            end
            check_eq($sformatf("%s busy@%0d", name, n), bus.busy, (n <= done_c));
            check_eq($sformatf("%s done@%0d", name, n), bus.done, (n == done_c));
            check_eq($sformatf("%s valid@%0d", name, n), bus.match_valid, exp_v);
            if (exp_v)
                check_eq($sformatf("%s num@%0d", name, n), bus.match_num, exp_num);
            if (n == done_c)
                check_eq($sformatf("%s found", name), bus.found, (ix.size() > 0));

            if (bus.match_valid) begin
                bus.match_ready = (hold_cnt >= stall);
                hold_cnt++;
            end else begin
                bus.match_ready = 1'b0;
                hold_cnt = 0;
            end
            bus.wr_en = (n == wr_at);
            if (n == wr_at) begin
                bus.wr_addr = (AW+LW)'(6 * R);
                bus.din     = cand[IW-1:0];
            end
            bus.start = (n == start_at);
            if (n == start_at) bus.hash_count = (AW+1)'(1);
            step();
        end
        bus.match_ready = 1'b0;
        bus.wr_en       = 1'b0;
        bus.start       = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] cand;
        bus.din         = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.hash_count  = '0;
        bus.multi       = 1'b0;
        bus.cmp_data    = '0;
        bus.start       = 1'b0;
        bus.match_ready = 1'b0;
        step();
        check_eq("reset busy", bus.busy, 0);
        check_eq("reset valid", bus.match_valid, 0);
        check_eq("reset done", bus.done, 0);
        check_eq("reset found", bus.found, 0);
        check_eq("reset num", bus.match_num, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < D; i++) write_word(i, CW'(32'hF000_0000 + i));
        for (int i = 0; i < 8; i++) write_word(i, CW'(32'h1000 + i));

        run_scan("single_hit", 8, 1'b0, CW'(32'h1005), 0, 0, 0);
        run_scan("no_hit", 8, 1'b0, CW'(32'hDEAD), 0, 0, 0);

        write_word(2, CW'(32'hABCD));
        write_word(3, CW'(32'hABCD));
        write_word(7, CW'(32'hABCD));
        run_scan("multi_stall", 8, 1'b1, CW'(32'hABCD), 5, 0, 0);
        run_scan("multi_fast", 8, 1'b1, CW'(32'hABCD), 0, 0, 0);
        run_scan("count_zero", 0, 1'b0, CW'(32'hABCD), 0, 0, 0);
        run_scan("count_over", D + 5, 1'b0, CW'(32'hDEAD), 0, 0, 0);
        run_scan("count_full_last", D, 1'b0, CW'(32'hF000_0000 + D - 1), 2, 0, 0);

        cand = CW'(32'h5A5A_5A5A);
        write_word(6, cand ^ CW'(32'hFF));
        run_scan("wr_during_scan", 8, 1'b0, cand, 0, 1, 4);
        run_scan("wr_after_check", 8, 1'b0, cand, 0, 0, 0);

        // Reset asserted while a match is being held.
        write_word(5, CW'(32'h1005));
        bus.hash_count  = (AW+1)'(8);
        bus.multi       = 1'b0;
        bus.cmp_data    = CW'(32'h1005);
        bus.match_ready = 1'b0;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !bus.match_valid; i++) step();
        check_eq("rst_hold valid before", bus.match_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_hold busy", bus.busy, 0);
        check_eq("rst_hold valid", bus.match_valid, 0);
        check_eq("rst_hold done", bus.done, 0);
        check_eq("rst_hold found", bus.found, 0);
        check_eq("rst_hold num", bus.match_num, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("rst_after done@%0d", i), bus.done, 0);
            check_eq($sformatf("rst_after busy@%0d", i), bus.busy, 0);
        end
        run_scan("rescan_after_rst", 8, 1'b0, CW'(32'h1005), 1, 0, 0);

        // Randomized scans over a small value alphabet so matches are frequent.
        for (int i = 0; i < D; i++) write_word(i, CW'(32'hC0DE_0000 + $urandom_range(0, 3)));
        for (int it = 0; it < 24; it++) begin
            int hc;
            for (int j = 0; j < 4; j++)
                write_word($urandom_range(0, D - 1), CW'(32'hC0DE_0000 + $urandom_range(0, 3)));
            hc = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(0, D + 5);
            run_scan($sformatf("rand%0d", it), hc, 1'($urandom_range(0, 1)),
                     CW'(32'hC0DE_0000 + $urandom_range(0, 4)), $urandom_range(0, 3), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
